data_mem_ctrl: RTL and testbench

- Parametrised RISC-V data memory for the core's MEM stage, successor to the single-port word RAM.
- Adds valid/ready request handshake, configurable read latency, and byte/half/word access with byte enables and sign/zero extension per funct3.
- Flags out-of-range, illegal-size and (optionally) misaligned accesses.
- Sits between the load/store unit and on-chip SRAM; one request in flight at a time.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 82 ++++++++
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the RISC-V data memory controller.
//   WORD_W       : data word width in bits
//   mem_size_e   : funct3 encodings of the legal access sizes
//   dmem_state_e : controller FSM states
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory (purely combinational).
// Build option: DMEM_MISALIGN_CHECK_EN enables the misaligned flag; without
// it the offending low address bits are simply ignored.
// Ports:
//   size       : funct3 access size
//   we         : 1 = store, 0 = load
//   addr_lo    : byte address bits [1:0]
//   wdata      : right-aligned store data
//   rdata_raw  : full word read from the array
//   be         : per-lane byte enables for a store
//   wdata_lane : store data replicated onto every lane it may land in
//   rdata_ext  : selected and sign/zero-extended load data
//   illegal    : unlisted size encoding, or BU/HU used for a store
//   misaligned : H with addr[0]=1 or W with addr[1:0]!=0 (checked builds only)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        size,
  input  logic              we,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rdata_raw,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wdata_lane,
  output logic [WORD_W-1:0] rdata_ext,
  output logic              illegal,
  output logic              misaligned
);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  logic [WORD_W-1:0] byte_shift;
  logic [WORD_W-1:0] half_shift;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Little-endian lane select: bring the addressed byte/half down to bit 0.
  // Halfwords only look at addr[1], so an odd H address behaves as even.
  assign byte_shift = rdata_raw >> {addr_lo, 3'b000};
  assign half_shift = rdata_raw >> {addr_lo[1], 4'b0000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = half_shift[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    be         = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel}
                                    : {24'h0, byte_sel};
      end
      SZ_H, SZ_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (size == SZ_H) ? {{16{half_sel[15]}}, half_sel}
                                    : {16'h0, half_sel};
        misaligned = MISALIGN_CHK && addr_lo[0];
      end
      SZ_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
        misaligned = MISALIGN_CHK && (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants only make sense for loads.
    if (we && (size == SZ_BU || size == SZ_HU)) illegal = 1'b1;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// RISC-V MEM-stage data memory with valid/ready request handshake,
// configurable read latency and byte/half/word access.
// Build option: DMEM_MISALIGN_CHECK_EN turns misaligned H/W accesses into
// errors (handled in dmem_lane_align).
// Parameters: DEPTH_WORDS (power of two), ADDR_W (>= log2(DEPTH_WORDS)+2),
//             RD_LAT (1..4, accept-to-response cycles).
// Ports:
//   clk, clr_n : clock and synchronous active-low reset
//   req_*      : request (valid/ready, we, funct3 size, byte addr, wdata)
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : extended load data; 0 for stores and errors
//   rsp_err    : out-of-range / illegal size / misaligned, with rsp_valid
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 16,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH_WORDS);
  // WAIT is entered with the counter at 0 and left after RD_LAT-1 cycles.
  localparam logic [1:0]        LAST_WAIT = 2'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

  dmem_state_e       state;
  logic [1:0]        lat_cnt;

  // Request fields captured at acceptance for use in the response cycle.
  logic              we_q;
  logic [2:0]        size_q;
  logic [1:0]        addr_lo_q;
  logic              err_q;
  logic [WORD_W-1:0] rd_word_q;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              oob;
  logic [IDX_W-1:0]  word_idx;
  logic              in_idle;
  logic [2:0]        la_size;
  logic              la_we;
  logic [1:0]        la_addr_lo;
  logic [3:0]        be;
  logic [WORD_W-1:0] wdata_lane;
  logic [WORD_W-1:0] rdata_ext;
  logic              illegal;
  logic              misaligned;
  logic              err_now;
  logic              mem_we;

  assign in_idle   = (state == IDLE);
  assign req_ready = in_idle && clr_n;
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[IDX_W+1:2];
  assign oob       = {1'b0, req_addr[ADDR_W-1:2]} >= DEPTH_LIM;

  // One shared aligner: in IDLE it steers the live request (store lanes and
  // error flags); afterwards it extends the captured read word for the response.
  assign la_size    = in_idle ? req_size       : size_q;
  assign la_we      = in_idle ? req_we         : we_q;
  assign la_addr_lo = in_idle ? req_addr[1:0]  : addr_lo_q;

  dmem_lane_align u_align (
    .size       (la_size),
    .we         (la_we),
    .addr_lo    (la_addr_lo),
    .wdata      (req_wdata),
    .rdata_raw  (rd_word_q),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  assign err_now = oob || illegal || misaligned;
  assign mem_we  = accept && req_we && !err_now;

  // NOTE: the array and the captured request fields carry no reset: contents
  // must survive clr_n, and the fields are always written before being used.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
    if (accept) begin
      rd_word_q <= mem[word_idx];
      we_q      <= req_we;
      size_q    <= req_size;
      addr_lo_q <= req_addr[1:0];
      err_q     <= err_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      // NOTE: non-blocking assignments throughout sequential logic so every
      // register samples pre-edge values regardless of statement order.
      state     <= IDLE;
      lat_cnt   <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_cnt <= 2'd0;
            state   <= (RD_LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAST_WAIT) state <= RESP;
          else                      lat_cnt <= lat_cnt + 2'd1;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_rdata <= (we_q || err_q) ? '0 : rdata_ext;
          lat_cnt   <= 2'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: two controllers (RD_LAT=1 and RD_LAT=3) share one
// request stream; a behavioural model predicts ready, response timing, data
// and errors for each, and a compare process checks them every cycle.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 10;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr_n;
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rdy  [2];
  logic          vld  [2];
  logic          rerr [2];
  logic [31:0]   rdat [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld[0]), .rsp_rdata(rdat[0]),
    .rsp_err(rerr[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(vld[1]), .rsp_rdata(rdat[1]),
    .rsp_err(rerr[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [2][DEPTH];
  int          cyc = 0;
  bit          pend    [2];
  int          acc_cyc [2];
  logic [31:0] q_rd    [2];
  bit          q_err   [2];
  bit          vexp    [2];
  logic [31:0] rexp    [2];
  bit          eexp    [2];

  task automatic model_access(input int d, input bit we, input logic [2:0] sz,
                              input int addr, input logic [31:0] wd,
                              output logic [31:0] rd, output bit e);
    int          idx;
    int          off;
    bit          is_b, is_h, is_w, legal;
    logic [31:0] w;
    logic [15:0] hv;
    logic [7:0]  bv;
    idx   = addr / 4;
    off   = addr % 4;
    is_b  = (sz == 3'd0) || (sz == 3'd4);
    is_h  = (sz == 3'd1) || (sz == 3'd5);
    is_w  = (sz == 3'd2);
    legal = (is_b || is_h || is_w) && !(we && (sz == 3'd4 || sz == 3'd5));
    e     = !legal || (idx >= DEPTH) ||
            (MIS_EN && ((is_h && (off % 2 == 1)) || (is_w && off != 0)));
    rd    = 32'h0;
    if (e) return;
    w = mmem[d][idx];
    if (we) begin
      if (is_w)      w = wd;
      else if (is_h) w[16*(off/2) +: 16] = wd[15:0];
      else           w[8*off +: 8] = wd[7:0];
      mmem[d][idx] = w;
    end else if (is_w) begin
      rd = w;
    end else if (is_h) begin
      hv = w[16*(off/2) +: 16];
      rd = (sz == 3'd1) ? {{16{hv[15]}}, hv} : {16'h0, hv};
    end else begin
      bv = w[8*off +: 8];
      rd = (sz == 3'd0) ? {{24{bv[7]}}, bv} : {24'h0, bv};
    end
  endtask

  // A request occupies a controller from its acceptance edge until the edge
  // lat cycles later, where the response becomes visible.
  initial begin
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; vexp[d] = 0; acc_cyc[d] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        vexp[d] = 0;
        if (!clr_n) begin
          pend[d] = 0;
        end else if (pend[d]) begin
          if (cyc == acc_cyc[d] + lat_of(d)) begin
            vexp[d] = 1; rexp[d] = q_rd[d]; eexp[d] = q_err[d]; pend[d] = 0;
          end
        end else if (req_valid) begin
          model_access(d, req_we, req_size, int'(req_addr), req_wdata, q_rd[d], q_err[d]);
          pend[d]    = 1;
          acc_cyc[d] = cyc;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int          rsp_cnt [2];
  int          rsp_cyc [2];
  logic [31:0] last_rd [2];
  logic        last_err[2];

  initial begin
    for (int d = 0; d < 2; d++) rsp_cnt[d] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d ready", d), 32'(rdy[d]), 32'(clr_n && !pend[d]));
        check($sformatf("dut%0d rsp_valid", d), 32'(vld[d]), 32'(vexp[d]));
        if (vexp[d] && vld[d]) begin
          check($sformatf("dut%0d rsp_rdata", d), rdat[d], rexp[d]);
          check($sformatf("dut%0d rsp_err", d), 32'(rerr[d]), 32'(eexp[d]));
        end
        if (vld[d]) begin
          rsp_cnt[d]++;
          rsp_cyc[d]  = cyc;
          last_rd[d]  = rdat[d];
          last_err[d] = rerr[d];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input bit we, input logic [2:0] sz, input int addr, input logic [31:0] wd);
    int c0, c1;
    bit done;
    @(negedge clk);
    req_we    = we;
    req_size  = sz;
    req_addr  = AW'(addr);
    req_wdata = wd;
    req_valid = 1'b1;
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    @(negedge clk);
    req_valid = 1'b0;
    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (rsp_cnt[0] > c0 && rsp_cnt[1] > c1) done = 1;
      else @(negedge clk);
    end
    check("rsp_seen", 32'(done), 32'd1);
  endtask

  task automatic both(input string name, input logic [31:0] exp_rd, input logic exp_err);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s rdata dut%0d", name, d), last_rd[d], exp_rd);
      check($sformatf("%s err dut%0d", name, d), 32'(last_err[d]), 32'(exp_err));
    end
  endtask

  logic [31:0] init_val [DEPTH];
  logic [2:0]  size_tbl [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6, 3'd7};

  initial begin
    int c0, c1;
    clr_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset rsp_valid", 32'(vld[d]), 32'd0);
      check("reset rsp_rdata", rdat[d], 32'd0);
      check("reset rsp_err", 32'(rerr[d]), 32'd0);
      check("reset ready low", 32'(rdy[d]), 32'd0);
    end
    clr_n = 1'b1;
    #1;
    check("idle ready", 32'(rdy[1]), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = $urandom;
      do_req(1, SZ_W, i * 4, init_val[i]);
    end

    do_req(1, SZ_W, 'h28, 32'h12341234);
    do_req(0, SZ_W, 'h28, 0);
    both("lw28", 32'h12341234, 1'b0);
    check("lw latency l1", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd1);
    check("lw latency l3", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd3);
    do_req(0, SZ_B,  'h2B, 0);             both("lb2b",  32'h00000012, 1'b0);
    do_req(0, SZ_B,  'h29, 0);             both("lb29",  32'h00000012, 1'b0);
    do_req(1, SZ_B,  'h2A, 32'h80);        both("sb2a",  32'h00000000, 1'b0);
    do_req(0, SZ_B,  'h2A, 0);             both("lb2a",  32'hFFFFFF80, 1'b0);
    do_req(0, SZ_BU, 'h2A, 0);             both("lbu2a", 32'h00000080, 1'b0);
    do_req(0, SZ_H,  'h2A, 0);             both("lh2a",  32'h00001280, 1'b0);
    do_req(0, SZ_HU, 'h2A, 0);             both("lhu2a", 32'h00001280, 1'b0);
    do_req(1, SZ_H,  'h28, 32'h8001);
    do_req(0, SZ_H,  'h28, 0);             both("lh28",  32'hFFFF8001, 1'b0);
    do_req(0, SZ_HU, 'h28, 0);             both("lhu28", 32'h00008001, 1'b0);

    do_req(1, SZ_W,  DEPTH * 4, 32'hDEADBEEF); both("sw_oob", 32'h0, 1'b1);
    do_req(1, 3'b011, 0, 32'hDEADBEEF);        both("sz011",  32'h0, 1'b1);
    do_req(1, SZ_BU, 0, 32'hFF);               both("sbu",    32'h0, 1'b1);
    do_req(0, SZ_W,  DEPTH * 4 + 8, 0);        both("lw_oob", 32'h0, 1'b1);
    do_req(0, SZ_W,  0, 0);                    both("word0",  init_val[0], 1'b0);

    // Held request: ignored while busy, taken on every IDLE cycle.
    c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_W; req_addr = AW'('h28); req_valid = 1'b1;
    repeat (12) @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("held accepts l1", 32'(rsp_cnt[0] - c0), 32'd6);
    check("held accepts l3", 32'(rsp_cnt[1] - c1), 32'd3);

    // Reset while a load waits; a store offered during reset is not taken.
    c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_W; req_addr = AW'('h28); req_valid = 1'b1;
    @(negedge clk);
    req_we = 1'b1; req_addr = AW'('h40); req_wdata = 32'hCAFEF00D; clr_n = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; clr_n = 1'b1;
    #1;
    check("ready after reset l1", 32'(rdy[0]), 32'd1);
    check("ready after reset l3", 32'(rdy[1]), 32'd1);
    repeat (6) @(negedge clk);
    check("dropped rsp l1", 32'(rsp_cnt[0] - c0), 32'd0);
    check("dropped rsp l3", 32'(rsp_cnt[1] - c1), 32'd0);
    do_req(0, SZ_W, 'h40, 0); both("no store in reset", init_val[16], 1'b0);
    do_req(0, SZ_W, 'h28, 0); both("kept after reset", 32'h12808001, 1'b0);

    do_req(1, SZ_W, 'h30, 32'hA5A5A5A5);
    do_req(1, SZ_H, 'h31, 32'h0000BEEF); both("sh31", 32'h0, MIS_EN);
    do_req(0, SZ_W, 'h30, 0);
    both("sh31 readback", MIS_EN ? 32'hA5A5A5A5 : 32'hA5A5BEEF, 1'b0);

    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), size_tbl[$urandom_range(0, 9)],
             int'($urandom_range(0, DEPTH * 4 + 32)), $urandom);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
